ex_mem_stage: RTL and testbench
===============================

// Module: ex_mem_stage
// PURPOSE
//  Parametrised EX->MEM pipeline stage with valid/ready handshake, 2-entry skid buffer,
//  synchronous flush and bubble gating. Sits between ALU/branch-adder stage and data memory.
//  Adds back-pressure, flush and asynchronous reset to the plain EX/MEM latch, and registers
//  the branch decision (pc_src_out, branch_target_out) for the fetch stage.
// PARAMETERS
//  DATA_W      32  width of add/alu/b2/shl2 data fields
//  REG_ADDR_W  5   destination register index width
//  CTRL_W      6   control bundle {jump,branch,mem_write,mem_read,reg_write,mem_to_reg}, [5:0]
//  SKID        1   1: 2-entry skid buffer, registered in_ready; 0: single entry, comb. in_ready
// PORTS
//  clk                in   1           rising-edge clock
//  rst_n              in   1           asynchronous reset, active low
//  flush              in   1           discard all held and incoming entries this edge
//  in_valid           in   1           EX stage offers an entry
//  in_ready           out  1           stage accepts entry this cycle
//  add_in, alu_in     in   DATA_W      branch adder result / ALU result
//  b2_in, shl2_in     in   DATA_W      store data / shifted jump target
//  mux_in             in   REG_ADDR_W  destination register
//  zf_in              in   1           ALU zero flag
//  ctrl_in            in   CTRL_W      control bundle
//  out_valid          out  1           MEM stage entry valid
//  out_ready          in   1           MEM stage consumes entry
//  add_out..mux_out, zf_out  out  as inputs  head-entry data fields
//  ctrl_out           out  CTRL_W      head-entry control; all-zero when out_valid=0
//  pc_src_out         out  1           out_valid & (jump | (branch & zf))
//  branch_target_out  out  DATA_W      jump ? shl2 : add (head entry)
//  occupancy          out  2           entries held (0..2; 0..1 if SKID=0)
// BEHAVIOUR
//  Reset (rst_n=0, async): occupancy=0, out_valid=0, all data/ctrl outputs 0, pc_src_out=0,
//   in_ready=1. Edge-independent; released on next rising clk with rst_n=1.
//  in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. FIFO order always.
//  Latency: accepted entry visible at out_valid on next edge when stage empty. Throughput 1/cycle.
//  States (SKID=1): EMPTY, ONE, TWO.
//   EMPTY: in_fire->ONE (entry to head). else EMPTY.
//   ONE: in_fire & !out_fire->TWO (entry to skid); in_fire & out_fire->ONE (head replaced);
//        !in_fire & out_fire->EMPTY; else hold.
//   TWO: out_fire->ONE (skid moves to head); else hold. in_fire impossible (in_ready=0).
//  in_ready (SKID=1) is a register: 1 in EMPTY/ONE, 0 in TWO; depends on no comb input.
//  SKID=0: single entry; in_ready = !out_valid | out_ready (combinational); occupancy 0/1.
//  flush=1 at an edge: next state EMPTY regardless of in_valid/out_fire; incoming entry
//   dropped; in_ready=1 next cycle. Data registers may keep stale values; ctrl_out zero.
//  Bubble gating: ctrl_out and pc_src_out forced 0 whenever out_valid=0 (no spurious
//   reg_write/mem_write). Data outputs undefined-but-stable when out_valid=0.
//  Head data/ctrl hold stable while out_valid & !out_ready (no change until out_fire).
//  branch_target_out: pure mux of head fields; jump has priority over branch.
//  No arithmetic; all fields pass through width-exact. zf ignored unless branch=1.
// STRUCTURE
//  ex_mem_pkg: CTRL_* bit indices (JUMP=5..MEM_TO_REG=0), state enum {EMPTY,ONE,TWO},
//   packed entry struct {add,alu,b2,shl2,mux,zf,ctrl} via DATA_W/REG_ADDR_W.
//  Sub-module pipe_skid_buf #(W) handles handshake/storage on packed entry vector;
//   ex_mem_stage packs/unpacks fields, gates ctrl, derives pc_src/branch_target.
// TESTING
//  1 Reset mid-traffic: occupancy=2, pull rst_n low between edges -> out_valid=0,
//    ctrl_out=0, in_ready=1 immediately; no entry emerges after release.
//  2 Streaming: out_ready=1, 8 back-to-back entries alu_in=1..8 -> out alu_out=1..8 on
//    consecutive cycles, 1-cycle latency, in_ready never drops.
//  3 Back-pressure: out_ready=0, send A(alu=0xA),B(0xB),C -> occupancy=2, in_ready=0,
//    C held by source; out_ready=1 -> A,B,C in order, head stable while stalled.
//  4 Flush with in_valid: occupancy=2, flush=1 and in_valid=1 same edge -> occupancy=0,
//    out_valid=0, ctrl_out=0; next entry emerges normally.
//  5 Branch: ctrl branch=1, zf=1, add=0x40 -> pc_src_out=1, target=0x40; zf=0 -> pc_src=0;
//    jump=1, shl2=0x100, add=0x40 -> target=0x100, pc_src=1.
//  6 SKID=0 build: out_ready=0 with entry held -> in_ready=0; out_ready=1 same cycle as
//    in_valid -> replace-in-place, no bubble.

Source files
------------

// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg
//   Shared definitions for the EX->MEM pipeline stage: control-bundle bit
//   positions, skid-buffer state encoding, the default packed entry layout
//   and an occupancy helper.
package ex_mem_pkg;

    localparam int EM_DATA_W     = 32;
    localparam int EM_REG_ADDR_W = 5;
    localparam int EM_CTRL_W     = 6;

    // Control bundle {jump,branch,mem_write,mem_read,reg_write,mem_to_reg}
    localparam int CTRL_JUMP       = 5;
    localparam int CTRL_BRANCH     = 4;
    localparam int CTRL_MEM_WRITE  = 3;
    localparam int CTRL_MEM_READ   = 2;
    localparam int CTRL_REG_WRITE  = 1;
    localparam int CTRL_MEM_TO_REG = 0;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_t;

    // Entry layout at the default widths; the stage re-declares the same
    // layout locally so it follows its own parameters.
    typedef struct packed {
        logic [EM_DATA_W-1:0]     add;
        logic [EM_DATA_W-1:0]     alu;
        logic [EM_DATA_W-1:0]     b2;
        logic [EM_DATA_W-1:0]     shl2;
        logic [EM_REG_ADDR_W-1:0] mux;
        logic                     zf;
        logic [EM_CTRL_W-1:0]     ctrl;
    } ex_mem_entry_t;

    function automatic logic [1:0] state_occupancy(input skid_state_t s);
        case (s)
            ST_ONE:  return 2'd1;
            ST_TWO:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/ex_mem_stage_skid.sv
// pipe_skid_buf
//   Valid/ready pipeline register holding up to two entries (SKID=1, in_ready
//   registered) or one entry (SKID=0, in_ready combinational). Synchronous
//   flush empties the buffer and drops the incoming entry.
// Ports
//   clk, rst_n            clock, async active-low reset
//   flush                 empty the buffer at this edge
//   in_valid/in_ready     upstream handshake, in_data payload
//   out_valid/out_ready   downstream handshake, out_data head payload
//   occupancy             entries held
//
// state    | meaning
// ST_EMPTY | nothing held, out_valid=0
// ST_ONE   | head entry valid, skid empty
// ST_TWO   | head and skid both valid, in_ready=0
module pipe_skid_buf
    import ex_mem_pkg::*;
#(
    parameter int W    = 8,
    parameter bit SKID = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   occupancy
);

    skid_state_t  state_q, state_d;
    logic [W-1:0] head_q, skid_q;
    logic         in_ready_q;
    logic         in_fire, out_fire;
    logic         load_head_in, load_head_skid, load_skid;

    assign out_valid = (state_q != ST_EMPTY);
    // Registered in_ready breaks the combinational path from out_ready.
    assign in_ready  = SKID ? in_ready_q : (!out_valid || out_ready);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign out_data  = head_q;
    assign occupancy = state_occupancy(state_q);

    always_comb begin
        state_d        = state_q;
        load_head_in   = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_d      = ST_ONE;
                    load_head_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    load_head_in = 1'b1;
                end else if (in_fire && SKID) begin
                    state_d   = ST_TWO;
                    load_skid = 1'b1;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (out_fire) begin
                    state_d        = ST_ONE;
                    load_head_skid = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush) begin
            state_d        = ST_EMPTY;
            load_head_in   = 1'b0;
            load_head_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            head_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_TWO);
            if (load_head_in) begin
                head_q <= in_data;
            end else if (load_head_skid) begin
                head_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage
//   EX->MEM pipeline stage: packs the EX results into one entry, passes it
//   through a valid/ready skid buffer, gates control on bubbles and derives
//   the registered branch decision for fetch.
// Ports
//   clk, rst_n, flush                          clock, async reset, flush
//   in_valid/in_ready, *_in                    EX-side handshake and fields
//   out_valid/out_ready, *_out                 MEM-side handshake and fields
//   pc_src_out, branch_target_out              branch decision of head entry
//   occupancy                                  entries held
module ex_mem_stage
    import ex_mem_pkg::*;
#(
    parameter int DATA_W     = EM_DATA_W,
    parameter int REG_ADDR_W = EM_REG_ADDR_W,
    parameter int CTRL_W     = EM_CTRL_W,
    parameter bit SKID       = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     add_in,
    input  logic [DATA_W-1:0]     alu_in,
    input  logic [DATA_W-1:0]     b2_in,
    input  logic [DATA_W-1:0]     shl2_in,
    input  logic [REG_ADDR_W-1:0] mux_in,
    input  logic                  zf_in,
    input  logic [CTRL_W-1:0]     ctrl_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     add_out,
    output logic [DATA_W-1:0]     alu_out,
    output logic [DATA_W-1:0]     b2_out,
    output logic [DATA_W-1:0]     shl2_out,
    output logic [REG_ADDR_W-1:0] mux_out,
    output logic                  zf_out,
    output logic [CTRL_W-1:0]     ctrl_out,
    output logic                  pc_src_out,
    output logic [DATA_W-1:0]     branch_target_out,
    output logic [1:0]            occupancy
);

    typedef struct packed {
        logic [DATA_W-1:0]     add;
        logic [DATA_W-1:0]     alu;
        logic [DATA_W-1:0]     b2;
        logic [DATA_W-1:0]     shl2;
        logic [REG_ADDR_W-1:0] mux;
        logic                  zf;
        logic [CTRL_W-1:0]     ctrl;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    entry_t in_entry, head;

    always_comb begin
        in_entry      = '0;
        in_entry.add  = add_in;
        in_entry.alu  = alu_in;
        in_entry.b2   = b2_in;
        in_entry.shl2 = shl2_in;
        in_entry.mux  = mux_in;
        in_entry.zf   = zf_in;
        in_entry.ctrl = ctrl_in;
    end

    pipe_skid_buf #(
        .W    (ENTRY_W),
        .SKID (SKID)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_entry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head),
        .occupancy (occupancy)
    );

    assign add_out  = head.add;
    assign alu_out  = head.alu;
    assign b2_out   = head.b2;
    assign shl2_out = head.shl2;
    assign mux_out  = head.mux;
    assign zf_out   = head.zf;

    // Data registers may hold stale values after a flush; gating control
    // keeps a bubble from writing registers or memory.
    assign ctrl_out   = out_valid ? head.ctrl : '0;
    assign pc_src_out = out_valid &&
                        (head.ctrl[CTRL_JUMP] || (head.ctrl[CTRL_BRANCH] && head.zf));
    assign branch_target_out = head.ctrl[CTRL_JUMP] ? head.shl2 : head.add;

endmodule

// File: tb/tb_ex_mem_stage.sv
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] add_in = '0, alu_in = '0, b2_in = '0, shl2_in = '0;
    logic [4:0]  mux_in = '0;
    logic        zf_in = 1'b0;
    logic [5:0]  ctrl_in = '0;

    logic        in_ready_1, out_valid_1, zf_out_1, pc_src_out_1;
    logic [31:0] add_out_1, alu_out_1, b2_out_1, shl2_out_1, branch_target_out_1;
    logic [4:0]  mux_out_1;
    logic [5:0]  ctrl_out_1;
    logic [1:0]  occupancy_1;

    logic        in_ready_0, out_valid_0, zf_out_0, pc_src_out_0;
    logic [31:0] add_out_0, alu_out_0, b2_out_0, shl2_out_0, branch_target_out_0;
    logic [4:0]  mux_out_0;
    logic [5:0]  ctrl_out_0;
    logic [1:0]  occupancy_0;

    always #5 clk = ~clk;

    ex_mem_stage #(.DATA_W(32), .REG_ADDR_W(5), .CTRL_W(6), .SKID(1'b1)) dut_skid (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_1),
        .add_in(add_in), .alu_in(alu_in), .b2_in(b2_in), .shl2_in(shl2_in),
        .mux_in(mux_in), .zf_in(zf_in), .ctrl_in(ctrl_in),
        .out_valid(out_valid_1), .out_ready(out_ready),
        .add_out(add_out_1), .alu_out(alu_out_1), .b2_out(b2_out_1), .shl2_out(shl2_out_1),
        .mux_out(mux_out_1), .zf_out(zf_out_1), .ctrl_out(ctrl_out_1),
        .pc_src_out(pc_src_out_1), .branch_target_out(branch_target_out_1),
        .occupancy(occupancy_1)
    );

    ex_mem_stage #(.DATA_W(32), .REG_ADDR_W(5), .CTRL_W(6), .SKID(1'b0)) dut_single (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_0),
        .add_in(add_in), .alu_in(alu_in), .b2_in(b2_in), .shl2_in(shl2_in),
        .mux_in(mux_in), .zf_in(zf_in), .ctrl_in(ctrl_in),
        .out_valid(out_valid_0), .out_ready(out_ready),
        .add_out(add_out_0), .alu_out(alu_out_0), .b2_out(b2_out_0), .shl2_out(shl2_out_0),
        .mux_out(mux_out_0), .zf_out(zf_out_0), .ctrl_out(ctrl_out_0),
        .pc_src_out(pc_src_out_0), .branch_target_out(branch_target_out_0),
        .occupancy(occupancy_0)
    );

    typedef struct packed {
        logic [31:0] add;
        logic [31:0] alu;
        logic [31:0] b2;
        logic [31:0] shl2;
        logic [4:0]  mux;
        logic        zf;
        logic [5:0]  ctrl;
    } ent_t;

    // Reference model: each stage is a FIFO of accepted entries with a
    // capacity (2 with skid, 1 without); flush or reset empties it.
    ent_t q1[$];
    ent_t q0[$];
    bit   acc1 = 1'b0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q1.delete();
            q0.delete();
            acc1 = 1'b0;
        end else begin
            ent_t e;
            bit   rdy1, rdy0, in1, out1, in0, out0;
            e    = '{add: add_in, alu: alu_in, b2: b2_in, shl2: shl2_in,
                     mux: mux_in, zf: zf_in, ctrl: ctrl_in};
            rdy1 = (q1.size() < 2);
            rdy0 = (q0.size() == 0) || out_ready;
            in1  = in_valid && rdy1;
            in0  = in_valid && rdy0;
            out1 = (q1.size() > 0) && out_ready;
            out0 = (q0.size() > 0) && out_ready;
            acc1 = in1 && !flush;
            if (flush) begin
                q1.delete();
                q0.delete();
            end else begin
                if (out1) void'(q1.pop_front());
                if (in1)  q1.push_back(e);
                if (out0) void'(q0.pop_front());
                if (in0)  q0.push_back(e);
            end
        end
    end

    task automatic check_dut(input string nm, input bit has, input ent_t e, input bit exp_rdy,
                             input int exp_occ, input logic ov, input logic ir,
                             input logic [1:0] occ, input ent_t act, input logic pc,
                             input logic [31:0] tgt);
        chk({nm, ".out_valid"}, 160'(ov), 160'(has));
        chk({nm, ".in_ready"}, 160'(ir), 160'(exp_rdy));
        chk({nm, ".occupancy"}, 160'(occ), 160'(exp_occ));
        if (has) begin
            chk({nm, ".entry"}, 160'(act), 160'(e));
            chk({nm, ".pc_src"}, 160'(pc), 160'(e.ctrl[5] | (e.ctrl[4] & e.zf)));
            chk({nm, ".target"}, 160'(tgt), 160'(e.ctrl[5] ? e.shl2 : e.add));
        end else begin
            chk({nm, ".ctrl_gated"}, 160'(act.ctrl), 160'(0));
            chk({nm, ".pc_src_gated"}, 160'(pc), 160'(0));
        end
    endtask

    always @(negedge clk) begin
        ent_t a1, a0, h1, h0;
        a1 = '{add: add_out_1, alu: alu_out_1, b2: b2_out_1, shl2: shl2_out_1,
               mux: mux_out_1, zf: zf_out_1, ctrl: ctrl_out_1};
        a0 = '{add: add_out_0, alu: alu_out_0, b2: b2_out_0, shl2: shl2_out_0,
               mux: mux_out_0, zf: zf_out_0, ctrl: ctrl_out_0};
        h1 = (q1.size() > 0) ? q1[0] : '0;
        h0 = (q0.size() > 0) ? q0[0] : '0;
        check_dut("skid", q1.size() > 0, h1, q1.size() < 2, q1.size(),
                  out_valid_1, in_ready_1, occupancy_1, a1, pc_src_out_1, branch_target_out_1);
        check_dut("single", q0.size() > 0, h0, (q0.size() == 0) || out_ready, q0.size(),
                  out_valid_0, in_ready_0, occupancy_0, a0, pc_src_out_0, branch_target_out_0);
    end

    task automatic rand_fields();
        add_in  = $urandom;
        alu_in  = $urandom;
        b2_in   = $urandom;
        shl2_in = $urandom;
        mux_in  = 5'($urandom);
        zf_in   = 1'($urandom);
        ctrl_in = 6'($urandom);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one entry and hold it until the skid stage accepts it.
    task automatic send(input logic [31:0] alu);
        int n;
        rand_fields();
        alu_in   = alu;
        in_valid = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!acc1 && n < 50);
        in_valid = 1'b0;
        chk("send.accept_bound", 160'(acc1), 160'(1));
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();
    endtask

    initial begin
        repeat (2) step();
        chk("reset.alu_out", 160'(alu_out_1), 160'(0));
        chk("reset.target", 160'(branch_target_out_1), 160'(0));
        chk("reset.in_ready", 160'(in_ready_1), 160'(1));
        rst_n = 1'b1;
        step();

        // streaming: one entry per cycle, one-cycle latency
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            rand_fields();
            alu_in   = 32'(i);
            in_valid = 1'b1;
            chk("stream.in_ready", 160'(in_ready_1), 160'(1));
            step();
            chk("stream.alu_out", 160'(alu_out_1), 160'(i));
        end
        drain();

        // back-pressure: A, B fill the skid stage, C waits at the source
        out_ready = 1'b0;
        send(32'hA);
        send(32'hB);
        rand_fields();
        alu_in   = 32'hC;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp.occupancy", 160'(occupancy_1), 160'(2));
            chk("bp.in_ready", 160'(in_ready_1), 160'(0));
            chk("bp.head_stable", 160'(alu_out_1), 160'(32'hA));
        end
        out_ready = 1'b1;
        step();
        chk("bp.second", 160'(alu_out_1), 160'(32'hB));
        step();
        chk("bp.third", 160'(alu_out_1), 160'(32'hC));
        drain();

        // flush with a simultaneous incoming entry
        out_ready = 1'b0;
        send(32'h11);
        send(32'h22);
        rand_fields();
        in_valid = 1'b1;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush.occupancy", 160'(occupancy_1), 160'(0));
        chk("flush.out_valid", 160'(out_valid_1), 160'(0));
        chk("flush.ctrl_out", 160'(ctrl_out_1), 160'(0));
        chk("flush.in_ready", 160'(in_ready_1), 160'(1));
        out_ready = 1'b1;
        send(32'h55);
        chk("flush.next_entry", 160'(alu_out_1), 160'(32'h55));
        drain();

        // branch decision
        out_ready = 1'b1;
        in_valid  = 1'b1;
        rand_fields();
        ctrl_in = 6'b010000; zf_in = 1'b1; add_in = 32'h40;
        step();
        chk("br.taken_pc_src", 160'(pc_src_out_1), 160'(1));
        chk("br.taken_target", 160'(branch_target_out_1), 160'(32'h40));
        ctrl_in = 6'b010000; zf_in = 1'b0;
        step();
        chk("br.not_taken_pc_src", 160'(pc_src_out_1), 160'(0));
        ctrl_in = 6'b100000; zf_in = 1'b0; shl2_in = 32'h100; add_in = 32'h40;
        step();
        chk("br.jump_pc_src", 160'(pc_src_out_1), 160'(1));
        chk("br.jump_target", 160'(branch_target_out_1), 160'(32'h100));
        drain();

        // single-entry build: stall, then replace in place
        out_ready = 1'b0;
        rand_fields();
        alu_in   = 32'h61;
        in_valid = 1'b1;
        step();
        chk("single.held", 160'(alu_out_0), 160'(32'h61));
        chk("single.in_ready_stalled", 160'(in_ready_0), 160'(0));
        out_ready = 1'b1;
        alu_in    = 32'h62;
        #1;
        chk("single.in_ready_comb", 160'(in_ready_0), 160'(1));
        step();
        chk("single.replace_valid", 160'(out_valid_0), 160'(1));
        chk("single.replace_data", 160'(alu_out_0), 160'(32'h62));
        drain();

        // reset mid-traffic with the skid stage full
        out_ready = 1'b0;
        send(32'h71);
        send(32'h72);
        chk("rst.pre_occupancy", 160'(occupancy_1), 160'(2));
        in_valid = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst.out_valid", 160'(out_valid_1), 160'(0));
        chk("rst.ctrl_out", 160'(ctrl_out_1), 160'(0));
        chk("rst.in_ready", 160'(in_ready_1), 160'(1));
        chk("rst.occupancy", 160'(occupancy_1), 160'(0));
        step();
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rst.no_entry", 160'(out_valid_1), 160'(0));
        end

        // randomized traffic with occasional flush
        for (int i = 0; i < 3000; i++) begin
            rand_fields();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            step();
        end
        flush = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
